// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-N up/down counter with wrap/saturate modes, range-checked load and event pulses
module mod_counter #(
    parameter int MOD   = 10,
    parameter int WIDTH = $clog2(MOD),
    parameter int INIT  = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_sat,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_cmp,
    output logic [WIDTH-1:0] o_count,
    output logic             o_max_count,
    output logic             o_min_count,
    output logic             o_match,
    output logic             o_wrap,
    output logic             o_sat_hit,
    output logic             o_load_err
);

    // One extra bit so MOD itself is representable when MOD == 2**WIDTH.
    localparam logic [WIDTH:0]   L_MOD  = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0]   L_TOP  = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH-1:0] L_INIT = WIDTH'(INIT);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_sat_hit;
    logic             r_load_err;

    logic [WIDTH:0]   w_ext;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;
    logic             w_sat_hit;
    logic             w_load_err;

    assign w_ext = {1'b0, r_count};
    assign w_inc = w_ext + 1'b1;
    assign w_dec = w_ext - 1'b1;

    always_comb begin
        w_next     = r_count;
        w_wrap     = 1'b0;
        w_sat_hit  = 1'b0;
        w_load_err = 1'b0;
        if (i_clr) begin
            w_next = '0;
        end else if (i_load) begin
            if ({1'b0, i_load_val} < L_MOD) begin
                w_next = i_load_val;
            end else begin
                w_next     = L_TOP[WIDTH-1:0];
                w_load_err = 1'b1;
            end
        end else if (i_en) begin
            if (i_up) begin
                if (w_ext == L_TOP) begin
                    if (i_sat) begin
                        w_sat_hit = 1'b1;
                    end else begin
                        w_next = '0;
                        w_wrap = 1'b1;
                    end
                end else begin
                    w_next = w_inc[WIDTH-1:0];
                end
            end else begin
                if (w_ext == '0) begin
                    if (i_sat) begin
                        w_sat_hit = 1'b1;
                    end else begin
                        w_next = L_TOP[WIDTH-1:0];
                        w_wrap = 1'b1;
                    end
                end else begin
                    w_next = w_dec[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count    <= L_INIT;
            r_wrap     <= 1'b0;
            r_sat_hit  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_next;
            r_wrap     <= w_wrap;
            r_sat_hit  <= w_sat_hit;
            r_load_err <= w_load_err;
        end
    end

    assign o_count     = r_count;
    assign o_max_count = (w_ext == L_TOP);
    assign o_min_count = (r_count == '0);
    assign o_match     = (r_count == i_cmp);
    assign o_wrap      = r_wrap;
    assign o_sat_hit   = r_sat_hit;
    assign o_load_err  = r_load_err;

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - directed self-checking bench for mod_counter (MOD=10 and MOD=8 instances)
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, sat, clr, load;
    logic [3:0] a_load_val, a_cmp;
    logic [2:0] b_load_val, b_cmp;

    logic [3:0] a_count;
    logic       a_max, a_min, a_match, a_wrap, a_sat, a_lerr;
    logic [2:0] b_count;
    logic       b_max, b_min, b_match, b_wrap, b_sat, b_lerr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mod_counter #(.MOD(10), .INIT(3)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_sat(sat),
        .i_clr(clr), .i_load(load), .i_load_val(a_load_val), .i_cmp(a_cmp),
        .o_count(a_count), .o_max_count(a_max), .o_min_count(a_min),
        .o_match(a_match), .o_wrap(a_wrap), .o_sat_hit(a_sat), .o_load_err(a_lerr)
    );

    mod_counter #(.MOD(8), .INIT(2)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_sat(sat),
        .i_clr(clr), .i_load(load), .i_load_val(b_load_val), .i_cmp(b_cmp),
        .o_count(b_count), .o_max_count(b_max), .o_min_count(b_min),
        .o_match(b_match), .o_wrap(b_wrap), .o_sat_hit(b_sat), .o_load_err(b_lerr)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample 1 ns after the rising edge; inputs are also changed here, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; up = 1'b0; sat = 1'b0; clr = 1'b0; load = 1'b0;
    endtask

    initial begin
        idle_inputs();
        a_load_val = '0; a_cmp = 4'd15; b_load_val = '0; b_cmp = 3'd7;
        rst = 1'b1;
        #3;
        check_val("rst_a_count", a_count, 3);
        check_val("rst_b_count", b_count, 2);
        check_val("rst_a_pulses", {a_wrap, a_sat, a_lerr}, 0);
        #10;
        rst = 1'b0;

        // idle: enable low, count holds at INIT
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("idle_count", a_count, 3);
            check_val("idle_pulses", {a_wrap, a_sat, a_lerr}, 0);
            check_val("idle_min_max", {a_min, a_max}, 0);
        end

        // wrap up from 0
        clr = 1'b1;
        step();
        check_val("clr_count", a_count, 0);
        check_val("clr_min", a_min, 1);
        clr = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            check_val("wrapup_count", a_count, i % 10);
            check_val("wrapup_wrap", a_wrap, (i == 10) ? 1 : 0);
            check_val("wrapup_max", a_max, (i == 9) ? 1 : 0);
            check_val("wrapup_sat", a_sat, 0);
        end

        // saturate down from 1
        idle_inputs(); load = 1'b1; a_load_val = 4'd1;
        step();
        check_val("load1_count", a_count, 1);
        idle_inputs(); en = 1'b1; up = 1'b0; sat = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_val("satdn_count", a_count, 0);
            check_val("satdn_sat", a_sat, (i >= 2) ? 1 : 0);
            check_val("satdn_wrap", a_wrap, 0);
        end

        // load with range check
        idle_inputs(); load = 1'b1; a_load_val = 4'd7;
        step();
        check_val("load7_count", a_count, 7);
        check_val("load7_err", a_lerr, 0);
        a_load_val = 4'd12;
        step();
        check_val("load12_count", a_count, 9);
        check_val("load12_err", a_lerr, 1);
        load = 1'b0;
        step();
        check_val("load_err_drop", a_lerr, 0);
        check_val("load_hold", a_count, 9);

        // priority: clear beats load and enable
        load = 1'b1; a_load_val = 4'd5;
        step();
        check_val("pri_pre5", a_count, 5);
        clr = 1'b1; load = 1'b1; a_load_val = 4'd2; en = 1'b1; up = 1'b1;
        step();
        check_val("pri_clr_count", a_count, 0);
        check_val("pri_clr_pulses", {a_wrap, a_sat, a_lerr}, 0);
        // load beats a wrapping step at count 9
        idle_inputs(); load = 1'b1; a_load_val = 4'd9;
        step();
        check_val("pri_pre9", a_count, 9);
        load = 1'b1; a_load_val = 4'd4; en = 1'b1; up = 1'b1; sat = 1'b0;
        step();
        check_val("pri_load_count", a_count, 4);
        check_val("pri_load_nowrap", a_wrap, 0);

        // power-of-two modulus: wrap down from 0
        idle_inputs(); clr = 1'b1;
        step();
        check_val("b_clr", b_count, 0);
        idle_inputs(); en = 1'b1; up = 1'b0; sat = 1'b0;
        step();
        check_val("b_wrapdn_count", b_count, 7);
        check_val("b_wrapdn_wrap", b_wrap, 1);
        check_val("b_wrapdn_max", b_max, 1);

        // async reset between edges clears the pending pulse immediately
        #2;
        rst = 1'b1;
        #1;
        check_val("async_b_count", b_count, 2);
        check_val("async_b_wrap", b_wrap, 0);
        check_val("async_a_count", a_count, 3);
        check_val("async_a_pulses", {a_wrap, a_sat, a_lerr}, 0);
        #4;
        rst = 1'b0;

        // compare-match while counting up from INIT=3
        idle_inputs(); a_cmp = 4'd4;
        #1;
        check_val("match_at3", a_match, 0);
        en = 1'b1; up = 1'b1;
        for (int i = 4; i <= 6; i++) begin
            step();
            check_val("match_count", a_count, i);
            check_val("match_flag", a_match, (i == 4) ? 1 : 0);
        end
        a_cmp = 4'd12;
        idle_inputs();
        #1;
        check_val("match_oob", a_match, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo-N up/down counter for the SPI project datapath. It counts to an arbitrary modulus, which need not be a power of two, and supports a wrap or saturate mode selectable at run time. It also provides synchronous load with range checking, a compare-match output and registered event pulses. It serves as a general bit/byte/frame counter for SPI control logic.

## Interface
Parameters:
- MOD, default 10, modulus; count range 0..MOD-1; legal MOD >= 2
- WIDTH, default $clog2(MOD), counter width; must satisfy 2^WIDTH >= MOD
- INIT, default 0, reset/initial count value; must be < MOD

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_en  in  1  count enable; one step per enabled cycle
- i_up  in  1  direction: 1 = increment, 0 = decrement
- i_sat  in  1  mode: 1 = saturate at bounds, 0 = wrap modulo MOD
- i_clr  in  1  synchronous clear to 0
- i_load  in  1  synchronous load of i_load_val
- i_load_val  in  WIDTH  load value
- i_cmp  in  WIDTH  compare value
- o_count  out  WIDTH  current count, registered
- o_max_count  out  1  o_count == MOD-1, combinational from register
- o_min_count  out  1  o_count == 0, combinational from register
- o_match  out  1  o_count == i_cmp, combinational
- o_wrap  out  1  registered one-cycle pulse: a wrap occurred on the last edge
- o_sat_hit  out  1  registered one-cycle pulse: an enabled step was blocked by saturation
- o_load_err  out  1  registered one-cycle pulse: the last load was out of range

## Operation
- Priority per edge: i_clr > i_load > i_en > hold. A lower-priority request in the same cycle is ignored and produces no pulse.
- Clear: count <= 0. All pulses are 0 on the next cycle.
- Load: if i_load_val < MOD, count <= i_load_val. Otherwise count <= MOD-1 (clamped) and o_load_err = 1 for one cycle. Load ignores i_en, i_up and i_sat.
- Up step with count < MOD-1: count+1.
- Up step with count == MOD-1:
  - wrap mode: count <= 0, o_wrap pulse
  - saturate mode: count holds, o_sat_hit pulse
- Down step with count > 0: count-1.
- Down step with count == 0:
  - wrap mode: count <= MOD-1, o_wrap pulse
  - saturate mode: count holds, o_sat_hit pulse
- Arithmetic is performed in WIDTH+1 bits, so no intermediate overflow is possible. Count never leaves 0..MOD-1, including when MOD == 2^WIDTH.
- Comparison with i_cmp >= MOD is legal; o_match simply stays 0.
- i_sat and i_up are sampled per cycle. Changing mode mid-count takes effect on the next enabled step with no other side effect.

## Timing
- Reset (i_rst high, asynchronous): o_count = INIT, o_wrap = o_sat_hit = o_load_err = 0. o_max_count, o_min_count and o_match reflect INIT immediately.
- Deassertion of reset is synchronised externally; the first update occurs on the first rising edge after release.
- Latency: one cycle from input to o_count. Pulses are registered on the same edge as the count update, so they align with the new o_count value.
- Each pulse lasts exactly one cycle per event. Back-to-back events, such as continuous wrapping with MOD=2, give consecutive high cycles.
- Reset asserted mid-operation aborts immediately. Any pending pulse is cleared and no event pulse is produced for the interrupted cycle.
- No handshake: every request is consumed in the cycle it is presented.

## Test plan
- Reset and idle: MOD=10, INIT=3, i_rst pulse, then i_en=0 for 5 cycles -> o_count=3 throughout, all pulses 0, o_min_count=0, o_max_count=0.
- Wrap up: MOD=10, i_sat=0, i_up=1, i_en=1 from 0 for 12 cycles -> count 1..9, 0, 1, 2; o_wrap high only in the cycle o_count becomes 0; o_max_count high while count=9.
- Saturate down: count=1, i_sat=1, i_up=0, i_en=1 for 3 cycles -> count 0, 0, 0; o_sat_hit high on the 2nd and 3rd cycles only; o_wrap stays 0.
- Load and range check: i_load=1 with i_load_val=7 -> count=7, o_load_err=0. i_load_val=12 -> count=9, o_load_err pulses once.
- Priority: i_clr=1, i_load=1, i_en=1 in the same cycle at count=5 -> count=0, no pulses. i_load=1 with i_en=1 at count=9 in wrap mode -> load wins, no o_wrap.
- Power-of-two edge and async reset: MOD=8, wrap down from 0 -> count=7 with o_wrap. Then i_rst asserted between clock edges -> o_count=INIT before the next edge and pulses 0. Match: i_cmp=4 -> o_match high only while count=4.
